// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a byte-wide RAM port between fetch and load/store, serialising little-endian accesses
module mem_port_arbiter #(
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic [31:0]           if_data,
    output logic                  if_done,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_width,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_done,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    owner_mem_q, owner_mem_d;
    logic                    last_mem_q, last_mem_d;
    logic [RAM_ADDR_W-1:0]   base_q, base_d;
    logic [2:0]              n_q, n_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             asm_q, asm_d;
    logic [31:0]             if_data_q, if_data_d;
    logic [31:0]             mem_rdata_q, mem_rdata_d;
    logic                    grant_mem;
    logic [2:0]              mem_n;
    logic [1:0]              byte_idx;
    logic [RAM_ADDR_W-1:0]   cur_addr;
    logic                    unused_addr_hi;

    // MEM wins a tie unless it won the previous grant, so neither side starves
    assign grant_mem      = mem_req && !(if_req && last_mem_q);
    assign mem_n          = mem_width == 2'b00 ? 3'd1 : mem_width == 2'b01 ? 3'd2 : 3'd4;
    assign byte_idx       = cnt_q[1:0] - 2'd1;
    assign cur_addr       = base_q + {{(RAM_ADDR_W-3){1'b0}}, cnt_q};
    assign unused_addr_hi = ^{if_addr[31:RAM_ADDR_W], mem_addr[31:RAM_ADDR_W]};
    assign if_data        = if_data_q;
    assign mem_rdata      = mem_rdata_q;

    // transaction context, assembly buffer and per-port result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_mem_q <= 1'b0;
            last_mem_q  <= 1'b0;
            base_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            last_mem_q  <= last_mem_d;
            base_q      <= base_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // arbitration, byte sequencing and RAM port drive
    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        last_mem_d  = last_mem_q;
        base_d      = base_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_addr    = '0;
        ram_wr      = 1'b0;
        ram_dout    = 8'h00;
        if_done     = 1'b0;
        mem_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    owner_mem_d = grant_mem;
                    last_mem_d  = grant_mem;
                    base_d      = grant_mem ? mem_addr[RAM_ADDR_W-1:0] : if_addr[RAM_ADDR_W-1:0];
                    n_d         = grant_mem ? mem_n : 3'd4;
                    wdata_d     = mem_wdata;
                    cnt_d       = 3'd0;
                    asm_d       = '0;
                    state_d     = (grant_mem && mem_we) ? WRITE : READ;
                end
            end
            READ: begin
                ram_addr = cnt_q < n_q ? cur_addr : '0;
                if (cnt_q != 3'd0) asm_d[{byte_idx, 3'b000} +: 8] = ram_din;
                cnt_d = cnt_q + 3'd1;
                if (!owner_mem_q && !if_req) begin
                    state_d = IDLE;
                end else if (cnt_q == n_q) begin
                    state_d = DONE;
                    if (owner_mem_q) mem_rdata_d = asm_d;
                    else if_data_d = asm_d;
                end
            end
            WRITE: begin
                ram_wr   = 1'b1;
                ram_addr = cur_addr;
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == n_q - 3'd1) state_d = DONE;
                else cnt_d = cnt_q + 3'd1;
            end
            DONE: begin
                if_done  = !owner_mem_q;
                mem_done = owner_mem_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
